regfile_mp_sb: RTL

Parametrised successor to the single-write, two-read CPU register file.
- Adds configurable width, depth and read-port count.
- Adds a second write port for a dual-issue or late-writeback path, and write-to-read bypass.
- Adds a per-register pending scoreboard, so issue logic can detect RAW hazards without a separate unit.
- Sits in the datapath between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_sb.sv | 69 ++++++
 rtl/regfile_mp_sb.sv | 118 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file with scoreboard.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width / address width
//   ZERO_ADDR                       : address of the optional hardwired-zero register
//   next_pend_delta()               : per-cycle change of the pending count
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR      = 0;

  // set_new: a set hit a non-pending register.
  // clr0/clr1: a distinct pending register was cleared and not re-set.
  // Result lies in -2..+1.
  function automatic logic signed [2:0] next_pend_delta(input logic set_new,
                                                        input logic clr0,
                                                        input logic clr1);
    logic signed [2:0] d;
    d = set_new ? 3'sd1 : 3'sd0;
    if (clr0) d = d - 3'sd1;
    if (clr1) d = d - 3'sd1;
    return d;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Pending-register scoreboard.
//   clk, rst               : clock, async active-low reset
//   set_ok / set_addr      : qualified scoreboard set (valid, non-zero address)
//   clr0_ok / clr0_addr    : qualified write on port 0 (clears pending)
//   clr1_ok / clr1_addr    : qualified write on port 1 (clears pending)
//   pending                : one pending bit per implemented register
//   pend_cnt               : registered number of pending registers
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              set_ok,
  input  logic [ADDR_W-1:0]                 set_addr,
  input  logic                              clr0_ok,
  input  logic [ADDR_W-1:0]                 clr0_addr,
  input  logic                              clr1_ok,
  input  logic [ADDR_W-1:0]                 clr1_addr,
  output logic [NUM_REGS-1:0]               pending,
  output logic [$clog2(NUM_REGS+1)-1:0]     pend_cnt
);

  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

  logic [NUM_REGS-1:0] pend_d, pend_q;
  logic [CNT_W-1:0]    pend_cnt_d, pend_cnt_q;
  logic                set_new, clr0_eff, clr1_eff;
  logic signed [2:0]   delta;

  // The count is tracked incrementally; a register hit by both write ports
  // is attributed to port 0 only, so a dual clear counts once.
  always_comb begin
    pend_d   = pend_q;
    set_new  = 1'b0;
    clr0_eff = 1'b0;
    clr1_eff = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (set_ok && set_addr == ADDR_W'(r)) begin
        pend_d[r] = 1'b1;
        if (!pend_q[r]) set_new = 1'b1;
      end else if (clr0_ok && clr0_addr == ADDR_W'(r)) begin
        pend_d[r] = 1'b0;
        if (pend_q[r]) clr0_eff = 1'b1;
      end else if (clr1_ok && clr1_addr == ADDR_W'(r)) begin
        pend_d[r] = 1'b0;
        if (pend_q[r]) clr1_eff = 1'b1;
      end
    end
    delta      = next_pend_delta(set_new, clr0_eff, clr1_eff);
    pend_cnt_d = pend_cnt_q + CNT_W'(delta);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pending  = pend_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: two write ports, NUM_RD combinational read
// ports with optional write bypass, and a per-register pending scoreboard.
//   clk, rst              : clock, async active-low reset
//   we0/waddr0/wdata0     : write port 0
//   we1/waddr1/wdata1     : write port 1 (wins over port 0 on same address)
//   raddr / rdata         : packed read addresses / data, port k at slice k
//   rbusy                 : per read port, addressed register is pending
//   sb_set / sb_addr      : mark a register pending
//   pend_cnt              : registered count of pending registers
//   wr_conflict           : registered, previous cycle wrote same address on both ports
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we0,
  input  logic [ADDR_W-1:0]              waddr0,
  input  logic [DATA_W-1:0]              wdata0,
  input  logic                           we1,
  input  logic [ADDR_W-1:0]              waddr1,
  input  logic [DATA_W-1:0]              wdata1,
  input  logic [NUM_RD*ADDR_W-1:0]       raddr,
  output logic [NUM_RD*DATA_W-1:0]       rdata,
  output logic [NUM_RD-1:0]              rbusy,
  input  logic                           sb_set,
  input  logic [ADDR_W-1:0]              sb_addr,
  output logic [$clog2(NUM_REGS+1)-1:0]  pend_cnt,
  output logic                           wr_conflict
);

  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic                wr_conflict_d, wr_conflict_q;
  logic                w0_ok, w1_ok, set_ok;
  logic [NUM_REGS-1:0] pending;

  // Implemented and not the hardwired-zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !(ZERO_REG && a == ADDR_W'(ZERO_ADDR));
  endfunction

  always_comb begin
    w0_ok         = we0 && addr_ok(waddr0);
    w1_ok         = we1 && addr_ok(waddr1);
    set_ok        = sb_set && addr_ok(sb_addr);
    wr_conflict_d = we0 && we1 && (waddr0 == waddr1);
  end

  always_comb begin
    mem_d = mem_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (w0_ok && waddr0 == ADDR_W'(r)) mem_d[r] = wdata0;
      if (w1_ok && waddr1 == ADDR_W'(r)) mem_d[r] = wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q         <= '{default: '0};
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Out-of-range addresses never match the decode loop, so they read 0/idle.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] arr;
    logic              pb, hit0, hit1;
    rdata = '0;
    rbusy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra  = raddr[k*ADDR_W +: ADDR_W];
      arr = '0;
      pb  = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (ra == ADDR_W'(r)) begin
          arr = mem_q[r];
          pb  = pending[r];
        end
      end
      hit0 = BYPASS && w0_ok && (waddr0 == ra);
      hit1 = BYPASS && w1_ok && (waddr1 == ra);
      if (addr_ok(ra)) begin
        rdata[k*DATA_W +: DATA_W] = hit1 ? wdata1 : (hit0 ? wdata0 : arr);
        rbusy[k]                  = pb && !(hit0 || hit1);
      end
    end
  end

  regfile_sb #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_ok    (set_ok),
    .set_addr  (sb_addr),
    .clr0_ok   (w0_ok),
    .clr0_addr (waddr0),
    .clr1_ok   (w1_ok),
    .clr1_addr (waddr1),
    .pending   (pending),
    .pend_cnt  (pend_cnt)
  );

  assign wr_conflict = wr_conflict_q;

endmodule
